e203_eai_csr_bridge: RTL and testbench

E203_EAI_CSR_BRIDGE -- requirements
Module: e203_eai_csr_bridge

---
 rtl/e203_eai_csr_bridge.sv | 118 +++++++++++
 tb/tb_e203_eai_csr_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/e203_eai_csr_bridge.sv
// Bridges core CSR accesses in the extended address window onto the EAI
// CSR channel, one transaction at a time, with a downstream timeout.
module e203_eai_csr_bridge #(
   parameter logic [11:0] CSR_BASE = 12'h7C0,
   parameter int          CSR_SIZE = 64,
   parameter int          TIMEOUT  = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_req_valid,
   output logic        csr_req_ready,
   input  logic [11:0] csr_req_addr,
   input  logic        csr_req_wr,
   input  logic [31:0] csr_req_wdata,
   output logic        csr_rsp_valid,
   input  logic        csr_rsp_ready,
   output logic [31:0] csr_rsp_rdata,
   output logic        csr_rsp_err,
   output logic        eai_csr_valid,
   input  logic        eai_csr_ready,
   output logic [11:0] eai_csr_addr,
   output logic        eai_csr_wr,
   output logic [31:0] eai_csr_wdata,
   input  logic [31:0] eai_csr_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   // 13-bit window bounds so a window touching 0xFFF cannot wrap to zero
   localparam logic [12:0] WIN_LO  = {1'b0, CSR_BASE};
   localparam logic [12:0] WIN_HI  = {1'b0, CSR_BASE} + 13'(CSR_SIZE);
   localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  to_cnt;
   logic        req_ready_q;
   logic        eai_valid_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic        in_range;

   assign in_range = ({1'b0, csr_req_addr} >= WIN_LO) && ({1'b0, csr_req_addr} < WIN_HI);

   assign csr_req_ready = req_ready_q;
   assign eai_csr_valid = eai_valid_q;
   assign csr_rsp_valid = rsp_valid_q;
   assign csr_rsp_rdata = rsp_rdata_q;
   assign csr_rsp_err   = rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         to_cnt        <= '0;
         req_ready_q   <= 1'b1;
         eai_valid_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         eai_csr_addr  <= '0;
         eai_csr_wr    <= 1'b0;
         eai_csr_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (csr_req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  if (in_range) begin
                     eai_csr_addr  <= csr_req_addr;
                     eai_csr_wr    <= csr_req_wr;
                     eai_csr_wdata <= csr_req_wdata;
                     to_cnt        <= '0;
                     eai_valid_q   <= 1'b1;
                     state         <= ISSUE;
                  end else begin
                     rsp_rdata_q <= '0;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            ISSUE: begin
               // A handshake in the final timeout cycle still completes normally
               if (eai_csr_ready) begin
                  rsp_rdata_q <= eai_csr_wr ? 32'h0 : eai_csr_rdata;
                  rsp_err_q   <= 1'b0;
                  eai_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else if (to_cnt == TO_LAST) begin
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  eai_valid_q <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            RESP: begin
               if (csr_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               req_ready_q <= 1'b1;
               eai_valid_q <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_e203_eai_csr_bridge.sv
// Randomised and directed bench for e203_eai_csr_bridge against a
// transaction-level outcome model (window test, wait count, timeout).
module tb_e203_eai_csr_bridge;

   localparam logic [11:0] BASE = 12'h7C0;
   localparam int          SIZE = 64;
   localparam int          TOUT = 16;

   logic        clk;
   logic        rst_n;
   logic        csr_req_valid;
   logic        csr_req_ready;
   logic [11:0] csr_req_addr;
   logic        csr_req_wr;
   logic [31:0] csr_req_wdata;
   logic        csr_rsp_valid;
   logic        csr_rsp_ready;
   logic [31:0] csr_rsp_rdata;
   logic        csr_rsp_err;
   logic        eai_csr_valid;
   logic        eai_csr_ready;
   logic [11:0] eai_csr_addr;
   logic        eai_csr_wr;
   logic [31:0] eai_csr_wdata;
   logic [31:0] eai_csr_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   e203_eai_csr_bridge #(.CSR_BASE(BASE), .CSR_SIZE(SIZE), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
      .csr_req_addr(csr_req_addr), .csr_req_wr(csr_req_wr), .csr_req_wdata(csr_req_wdata),
      .csr_rsp_valid(csr_rsp_valid), .csr_rsp_ready(csr_rsp_ready),
      .csr_rsp_rdata(csr_rsp_rdata), .csr_rsp_err(csr_rsp_err),
      .eai_csr_valid(eai_csr_valid), .eai_csr_ready(eai_csr_ready),
      .eai_csr_addr(eai_csr_addr), .eai_csr_wr(eai_csr_wr), .eai_csr_wdata(eai_csr_wdata),
      .eai_csr_rdata(eai_csr_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // d = wait cycles before downstream ready, rd = cycles csr_rsp_ready is withheld
   task automatic run_txn(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                          input int d, input logic [31:0] rdv, input int rd);
      bit          inr;
      int          exp_k, exp_at;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          eai_cnt, rsp_cnt, rsp_at;
      bit          done, pay_ok, hold_ok, busy_ok;
      logic [31:0] r0;
      logic        e0;

      inr       = (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + SIZE);
      exp_k     = !inr ? 0 : (d < TOUT ? d + 1 : TOUT);
      exp_err   = !inr || (d >= TOUT);
      exp_rdata = (exp_err || wr) ? 32'h0 : rdv;
      exp_at    = exp_k + 1;

      eai_cnt = 0; rsp_cnt = 0; rsp_at = 0;
      done = 0; pay_ok = 1; hold_ok = 1; busy_ok = 1;
      r0 = '0; e0 = 1'b0;

      check("req_ready_idle", 64'(csr_req_ready), 64'(1));
      csr_req_valid = 1'b1;
      csr_req_addr  = addr;
      csr_req_wr    = wr;
      csr_req_wdata = wdata;
      eai_csr_rdata = rdv;
      @(posedge clk);
      #1 csr_req_valid = 1'b0;
      csr_req_addr  = $urandom;
      csr_req_wdata = $urandom;

      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (eai_csr_valid) begin
            eai_cnt++;
            if (eai_csr_addr !== addr || eai_csr_wr !== wr || eai_csr_wdata !== wdata) pay_ok = 0;
         end
         // after the downstream window closes, ready stays high as a late ready
         eai_csr_ready = eai_csr_valid ? (eai_cnt == d + 1) : 1'b1;
         if (csr_rsp_valid) begin
            rsp_cnt++;
            if (rsp_cnt == 1) begin
               rsp_at = c;
               r0 = csr_rsp_rdata;
               e0 = csr_rsp_err;
            end else if (csr_rsp_rdata !== r0 || csr_rsp_err !== e0) begin
               hold_ok = 0;
            end
            eai_csr_rdata = $urandom;
            csr_rsp_ready = (rsp_cnt == rd + 1);
         end else if (rsp_cnt > 0) begin
            done = 1;
            break;
         end
         if (csr_req_ready) busy_ok = 0;
      end

      check("txn_done_in_budget", 64'(done), 64'(1));
      check("eai_valid_cycles", 64'(eai_cnt), 64'(exp_k));
      check("rsp_latency", 64'(rsp_at), 64'(exp_at));
      check("rsp_rdata", 64'(r0), 64'(exp_rdata));
      check("rsp_err", 64'(e0), 64'(exp_err));
      check("eai_payload_stable", 64'(pay_ok), 64'(1));
      check("rsp_held_stable", 64'(hold_ok), 64'(1));
      check("req_ready_low_busy", 64'(busy_ok), 64'(1));
      check("rsp_cycles", 64'(rsp_cnt), 64'(rd + 1));
      csr_rsp_ready = 1'b0;
   endtask

   initial begin
      bit          quiet;
      logic [11:0] a;

      rst_n = 1'b0;
      csr_req_valid = 1'b0; csr_req_addr = '0; csr_req_wr = 1'b0; csr_req_wdata = '0;
      csr_rsp_ready = 1'b0; eai_csr_ready = 1'b0; eai_csr_rdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 64'(csr_req_ready), 64'(1));
      check("rst_eai_valid", 64'(eai_csr_valid), 64'(0));
      check("rst_rsp_valid", 64'(csr_rsp_valid), 64'(0));
      check("rst_eai_addr", 64'(eai_csr_addr), 64'(0));
      check("rst_eai_wr", 64'(eai_csr_wr), 64'(0));
      check("rst_eai_wdata", 64'(eai_csr_wdata), 64'(0));
      check("rst_rsp_rdata", 64'(csr_rsp_rdata), 64'(0));
      check("rst_rsp_err", 64'(csr_rsp_err), 64'(0));

      run_txn(12'h7C5, 1'b0, 32'h0, 0, 32'hDEADBEEF, 0);
      run_txn(12'h7FF, 1'b1, 32'h12345678, 3, 32'hA5A5A5A5, 0);
      run_txn(12'h7BF, 1'b0, 32'h0, 0, 32'h11111111, 0);
      run_txn(12'h800, 1'b0, 32'h0, 0, 32'h22222222, 0);
      run_txn(12'h7C1, 1'b0, 32'h0, 100, 32'h33333333, 0);
      run_txn(12'h7C0, 1'b0, 32'h0, 15, 32'h44444444, 0);
      run_txn(12'h7E0, 1'b0, 32'h0, 1, 32'hCAFEF00D, 5);
      run_txn(12'h7D0, 1'b1, 32'h0BADF00D, 2, 32'h55555555, 1);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       a = BASE + 12'($urandom_range(0, SIZE - 1));
            1:       a = ($urandom_range(0, 1) == 0) ? BASE - 12'd1 : BASE + 12'(SIZE);
            2:       a = 12'($urandom);
            default: a = ($urandom_range(0, 1) == 0) ? BASE : BASE + 12'(SIZE - 1);
         endcase
         run_txn(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 20), $urandom,
                 $urandom_range(0, 3));
      end

      // reset in the middle of a downstream access
      eai_csr_ready = 1'b0;
      csr_req_valid = 1'b1; csr_req_addr = 12'h7C1; csr_req_wr = 1'b0; csr_req_wdata = 32'h0;
      @(posedge clk);
      #1 csr_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_eai_valid", 64'(eai_csr_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_eai_valid", 64'(eai_csr_valid), 64'(0));
      check("async_reset_rsp_valid", 64'(csr_rsp_valid), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      eai_csr_ready = 1'b1;
      csr_rsp_ready = 1'b1;
      quiet = 1;
      repeat (20) begin
         @(negedge clk);
         if (csr_rsp_valid || eai_csr_valid || !csr_req_ready) quiet = 0;
      end
      check("post_reset_quiet_idle", 64'(quiet), 64'(1));
      csr_rsp_ready = 1'b0;
      run_txn(12'h7C2, 1'b0, 32'h0, 0, 32'h600DCAFE, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
